// File: rtl/img2col_window_gen_if.sv
// ---------------------------------------------------------------------------
// img2col_window_gen_if
// Purpose : valid/ready stream bundle used on both sides of the img2col
//           window generator (pixel beats in, flattened patches out).
// Params  : W - payload width in bits
// Signals : valid - payload valid (master drives)
//           ready - sink accepts payload (slave drives)
//           data  - payload
// Modports: master (source side), slave (sink side)
// ---------------------------------------------------------------------------
interface img2col_window_gen_if #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/img2col_window_gen.sv
// ---------------------------------------------------------------------------
// img2col_window_gen
// Purpose : parametrised img2col window generator. Consumes a raster-order
//           pixel stream (CH lanes per beat), keeps K-1 rows in line buffers
//           plus a KxK shift window, and emits one flattened KxKxCH patch per
//           valid output position at a runtime stride of 1 or 2.
// Ports   : clk      - clock, rising edge
//           nrst     - asynchronous reset, active HIGH (despite the name)
//           start    - one-cycle frame start pulse, honoured only in IDLE
//           stride   - 2 selects stride 2, anything else stride 1; latched
//                      on start
//           in_bus   - slave stream, CH*DATA_W pixel beats
//           out_bus  - master stream, K*K*CH*DATA_W patches; tap (r,c,ch)
//                      at word ((r*K+c)*CH+ch), r=0 is the top row
//           busy     - frame in progress (STREAM/DRAIN/DONE)
//           done     - one-cycle pulse after the last patch handshake
// Config  : IMG2COL_ZERO_PAD_EN - when defined, 'same' zero padding of
//           P=(K-1)/2 is applied around the image; pad pixels are generated
//           internally without consuming input beats.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// STREAM| walking the (virtual) grid, accepting pixels, emitting patches
// DRAIN | all pixels taken, waiting for the final patch to be handshaken
// DONE  | done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module img2col_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int CH     = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic [1:0]                 stride,
    img2col_window_gen_if.slave        in_bus,
    img2col_window_gen_if.master       out_bus,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = CH * DATA_W;
    localparam int OW = K * K * PW;
`ifdef IMG2COL_ZERO_PAD_EN
    localparam int P  = (K - 1) / 2;
`else
    localparam int P  = 0;
`endif
    localparam int GW = IMG_W + 2 * P;
    localparam int GH = IMG_H + 2 * P;
    localparam int CW = $clog2(GW);
    localparam int RW = $clog2(GH);

    // Parity of K-1: with stride 2, (n-(K-1)) is even iff n[0] matches it.
    localparam logic KM1_LSB = 1'((K - 1) % 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            stride2;

    // lb[0] holds the oldest buffered row; lb[K-2] the most recent one.
    logic [PW-1:0]   lb       [K-1][GW];
    logic [PW-1:0]   win      [K][K];
    logic [PW-1:0]   newcol   [K];
    logic [PW-1:0]   next_win [K][K];
    logic [OW-1:0]   next_flat;

    logic            can_load;
    logic            step;
    logic            last_pos;
    logic            emit_pos;
    logic [PW-1:0]   pix;

    assign can_load = !out_bus.valid || out_bus.ready;

`ifdef IMG2COL_ZERO_PAD_EN
    logic pad_pos;

    assign pad_pos = (row < RW'(P)) || (row >= RW'(P + IMG_H)) ||
                     (col < CW'(P)) || (col >= CW'(P + IMG_W));

    // Pad positions advance on their own whenever the output can take a
    // patch; the input stream is held off for those cycles.
    assign in_bus.ready = (state == S_STREAM) && can_load && !pad_pos;
    assign step         = (state == S_STREAM) && can_load && (pad_pos || in_bus.valid);
    assign pix          = pad_pos ? '0 : in_bus.data;
`else
    assign in_bus.ready = (state == S_STREAM) && can_load;
    assign step         = in_bus.ready && in_bus.valid;
    assign pix          = in_bus.data;
`endif

    assign last_pos = (row == RW'(GH - 1)) && (col == CW'(GW - 1));

    assign emit_pos = (row >= RW'(K - 1)) && (col >= CW'(K - 1)) &&
                      (!stride2 || ((row[0] == KM1_LSB) && (col[0] == KM1_LSB)));

    // Column entering the window: K-1 buffered rows above, new pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            newcol[r] = lb[r][col];
        end
        newcol[K-1] = pix;
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                next_win[r][c] = win[r][c+1];
            end
            next_win[r][K-1] = newcol[r];
        end
    end

    always_comb begin
        next_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                next_flat[(r*K + c)*PW +: PW] = next_win[r][c];
            end
        end
    end

    // Storage: contents are don't-care after reset because a patch is only
    // emitted once K full rows of the current frame have passed through.
    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < K - 2; r++) begin
                lb[r][col] <= lb[r+1][col];
            end
            lb[K-2][col] <= pix;
            win <= next_win;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state         <= S_IDLE;
            col           <= '0;
            row           <= '0;
            stride2       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_bus.valid <= 1'b0;
            out_bus.data  <= '0;
        end else begin
            done <= 1'b0;

            // step implies can_load, so a new patch never overwrites an
            // unaccepted one; a simultaneous handshake simply reloads.
            if (step && emit_pos) begin
                out_bus.valid <= 1'b1;
                out_bus.data  <= next_flat;
            end else if (out_bus.ready) begin
                out_bus.valid <= 1'b0;
            end

            if (step) begin
                if (col == CW'(GW - 1)) begin
                    col <= '0;
                    row <= last_pos ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        stride2 <= (stride == 2'd2);
                        busy    <= 1'b1;
                        col     <= '0;
                        row     <= '0;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (step && last_pos) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Holding register empty or being emptied this cycle.
                    if (can_load) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img2col_window_gen.sv
module tb_img2col_window_gen;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    localparam int CH     = 3;
    localparam int PW     = CH * DATA_W;
    localparam int OW     = K * K * PW;
`ifdef IMG2COL_ZERO_PAD_EN
    localparam int P      = 2;
`else
    localparam int P      = 0;
`endif
    localparam int GW     = IMG_W + 2 * P;
    localparam int GH     = IMG_H + 2 * P;
    localparam int NBEATS = IMG_W * IMG_H;
    localparam int LIMIT  = 20000;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic [1:0] stride;
    logic       busy;
    logic       done;

    img2col_window_gen_if #(.W(PW)) in_if ();
    img2col_window_gen_if #(.W(OW)) out_if ();

    img2col_window_gen #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .CH     (CH)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .stride (stride),
        .in_bus (in_if),
        .out_bus(out_if),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lane ch of real pixel number b = b + ch*1000.
    function automatic logic [PW-1:0] beat_data(input int b);
        logic [PW-1:0] v;
        v = '0;
        for (int ch = 0; ch < CH; ch++) v[ch*DATA_W +: DATA_W] = DATA_W'(b + ch * 1000);
        return v;
    endfunction

    function automatic logic [PW-1:0] vpix(input int vr, input int vc);
        if (vr < P || vr >= P + IMG_H || vc < P || vc >= P + IMG_W) return '0;
        return beat_data((vr - P) * IMG_W + (vc - P));
    endfunction

    function automatic logic [OW-1:0] exp_patch(input int tr, input int tc);
        logic [OW-1:0] d;
        d = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                d[(r*K + c)*PW +: PW] = vpix(tr + r, tc + c);
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] tap(input logic [OW-1:0] d, input int r, input int c, input int ch);
        return d[((r*K + c)*CH + ch)*DATA_W +: DATA_W];
    endfunction

    typedef struct {
        int stride_in;
        int bp;          // 0: out_ready=1, 1: random ready + stall bursts
        bit poke;        // pulse start mid-frame (must be ignored)
        int exp_patches;
        int exp_first;   // input beats accepted when first patch appears
    } vec_t;

    task automatic run_frame(input int fid, input int stride_v, input int bp, input bit poke,
                             input int abort_after, input int exp_patches, input int exp_first);
        int s, npc, beats, got, done_cnt, post, cyc, stall;
        bit first_seen, saw_block, held, aborted, in_hs, out_hs;
        logic [OW-1:0] held_data, exp_d;
        s   = (stride_v == 2) ? 2 : 1;
        npc = (GW - K) / s + 1;
        beats = 0; got = 0; done_cnt = 0; post = 0; cyc = 0; stall = 0;
        first_seen = 0; saw_block = 0; held = 0; aborted = 0;
        held_data = '0;

        @(negedge clk);
        start  = 1'b1;
        stride = 2'(stride_v);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);

        while (cyc < LIMIT && post < 3 && !aborted) begin
            if (bp == 0) begin
                out_if.ready = 1'b1;
                in_if.valid  = (beats < NBEATS);
            end else begin
                if (stall > 0) begin
                    out_if.ready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 99) < 4) begin
                    out_if.ready = 1'b0;
                    stall = 9;
                end else begin
                    out_if.ready = 1'($urandom_range(0, 1));
                end
                in_if.valid = (beats < NBEATS) && ($urandom_range(0, 3) != 0);
            end
            in_if.data = beat_data(beats < NBEATS ? beats : 0);
            if (poke && cyc == 50) begin
                start  = 1'b1;
                stride = 2'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            if (held) begin
                chk("hold_stable", {63'd0, out_if.valid && (out_if.data == held_data)}, 64'd1);
            end
            if (out_if.valid && !first_seen) begin
                first_seen = 1;
                chk("first_patch_beats", 64'(beats), 64'(exp_first));
            end
            if (busy && in_if.valid && !in_if.ready) saw_block = 1;
            in_hs  = in_if.valid && in_if.ready;
            out_hs = out_if.valid && out_if.ready;
            if (out_hs) begin
                exp_d = exp_patch((got / npc) * s, (got % npc) * s);
                checks++;
                if (out_if.data !== exp_d) begin
                    int t;
                    t = 0;
                    for (int i = K*K*CH - 1; i >= 0; i--)
                        if (out_if.data[i*DATA_W +: DATA_W] !== exp_d[i*DATA_W +: DATA_W]) t = i;
                    errors++;
                    $display("FAIL patch_data frame %0d patch %0d tap %0d: got %0d expected %0d",
                             fid, got, t, out_if.data[t*DATA_W +: DATA_W], exp_d[t*DATA_W +: DATA_W]);
                end
                if (got == 0) begin
`ifdef IMG2COL_ZERO_PAD_EN
                    chk("pad_tap_0_0_0", 64'(tap(out_if.data, 0, 0, 0)), 64'd0);
                    chk("pad_tap_1_4_2", 64'(tap(out_if.data, 1, 4, 2)), 64'd0);
                    chk("pad_tap_2_2_1", 64'(tap(out_if.data, 2, 2, 1)), 64'd1000);
                    chk("pad_tap_3_3_0", 64'(tap(out_if.data, 3, 3, 0)), 64'd29);
`else
                    chk("tap_0_0_2", 64'(tap(out_if.data, 0, 0, 2)), 64'd2000);
                    chk("tap_4_4_1", 64'(tap(out_if.data, 4, 4, 1)), 64'd1116);
`endif
                end
                got++;
            end
            held = out_if.valid && !out_if.ready;
            if (held) held_data = out_if.data;
            @(posedge clk);
            if (in_hs) beats++;
            if (abort_after > 0 && beats >= abort_after) aborted = 1;
            @(negedge clk);
            cyc++;
        end
        in_if.valid = 1'b0;
        start = 1'b0;
        if (aborted) return;
        chk("frame_terminated", {63'd0, cyc < LIMIT}, 64'd1);
        chk("patch_count", 64'(got), 64'(exp_patches));
        chk("beat_count", 64'(beats), 64'(NBEATS));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_in_ready", {63'd0, in_if.ready}, 64'd0);
        if (bp == 1) chk("backpressure_seen", {63'd0, saw_block}, 64'd1);
    endtask

    vec_t tbl[5];

    initial begin
`ifdef IMG2COL_ZERO_PAD_EN
        tbl[0] = '{stride_in: 1, bp: 0, poke: 1'b0, exp_patches: 784, exp_first: 59};
        tbl[1] = '{stride_in: 2, bp: 0, poke: 1'b1, exp_patches: 196, exp_first: 59};
        tbl[2] = '{stride_in: 1, bp: 1, poke: 1'b0, exp_patches: 784, exp_first: 59};
        tbl[3] = '{stride_in: 0, bp: 0, poke: 1'b0, exp_patches: 784, exp_first: 59};
        tbl[4] = '{stride_in: 3, bp: 0, poke: 1'b0, exp_patches: 784, exp_first: 59};
`else
        tbl[0] = '{stride_in: 1, bp: 0, poke: 1'b0, exp_patches: 576, exp_first: 117};
        tbl[1] = '{stride_in: 2, bp: 0, poke: 1'b1, exp_patches: 144, exp_first: 117};
        tbl[2] = '{stride_in: 1, bp: 1, poke: 1'b0, exp_patches: 576, exp_first: 117};
        tbl[3] = '{stride_in: 0, bp: 0, poke: 1'b0, exp_patches: 576, exp_first: 117};
        tbl[4] = '{stride_in: 3, bp: 0, poke: 1'b0, exp_patches: 576, exp_first: 117};
`endif
        nrst         = 1'b1;
        start        = 1'b0;
        stride       = 2'd0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_if.valid}, 64'd0);
        chk("rst_out_data_zero", {63'd0, out_if.data == '0}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_in_ready", {63'd0, in_if.ready}, 64'd0);
        nrst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(i, tbl[i].stride_in, tbl[i].bp, tbl[i].poke, 0,
                      tbl[i].exp_patches, tbl[i].exp_first);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a frame, then a clean frame must follow.
        run_frame(10, 1, 0, 1'b0, 300, tbl[0].exp_patches, tbl[0].exp_first);
        nrst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_if.valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_out_data_zero", {63'd0, out_if.data == '0}, 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_hold_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hold_in_ready", {63'd0, in_if.ready}, 64'd0);
        nrst = 1'b0;
        @(negedge clk);
        run_frame(11, 1, 0, 1'b0, 0, tbl[0].exp_patches, tbl[0].exp_first);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
